// File: rtl/dm9000a_bus_ctrl_pkg.sv
// Shared types and default timing for the DM9000A host bus controller.
package dm9000a_pkg;

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned DATA_W = 16;

  localparam int unsigned DEF_SETUP_CYC = 1;
  localparam int unsigned DEF_PULSE_CYC = 2;
  localparam int unsigned DEF_HOLD_CYC  = 1;
  localparam int unsigned DEF_RST_CYC   = 16;
  localparam int unsigned DEF_RST_WAIT  = 32;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    ST_RST_LOW,
    ST_RST_WAIT,
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/dm9000a_bus_ctrl_if.sv
// Host request side and DM9000A pad side of the bus controller.
interface dm9000a_bus_ctrl_if;
  import dm9000a_pkg::*;

  logic              iREQ;
  logic              iWE;
  logic              iCMD_SEL;
  logic [DATA_W-1:0] iWDATA;
  logic [DATA_W-1:0] oRDATA;
  logic              oBUSY;
  logic              oDONE;
  logic [DATA_W-1:0] oDATA;
  logic [DATA_W-1:0] iDATA;
  logic              oCMD;
  logic              oRD_N;
  logic              oWR_N;
  logic              oCS_N;
  logic              oRST_N;
  logic              iINT;
  logic              oINT;

  modport master (
    output iREQ, iWE, iCMD_SEL, iWDATA, iDATA, iINT,
    input  oRDATA, oBUSY, oDONE, oDATA, oCMD, oRD_N, oWR_N, oCS_N, oRST_N, oINT
  );

  modport slave (
    input  iREQ, iWE, iCMD_SEL, iWDATA, iDATA, iINT,
    output oRDATA, oBUSY, oDONE, oDATA, oCMD, oRD_N, oWR_N, oCS_N, oRST_N, oINT
  );

endinterface

// File: rtl/dm9000a_bus_ctrl_sync2.sv
// Two-flop synchroniser for the raw DM9000A interrupt line.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dm9000a_bus_ctrl.sv
// DM9000A host bus sequencer: chip reset, then single CS/RD/WR accesses
// with programmable setup/strobe/hold timing; all outputs registered.
module dm9000a_bus_ctrl
  import dm9000a_pkg::*;
#(
  parameter int unsigned SETUP_CYC = DEF_SETUP_CYC,
  parameter int unsigned PULSE_CYC = DEF_PULSE_CYC,
  parameter int unsigned HOLD_CYC  = DEF_HOLD_CYC,
  parameter int unsigned RST_CYC   = DEF_RST_CYC,
  parameter int unsigned RST_WAIT  = DEF_RST_WAIT
) (
  input logic               iCLK,
  input logic               iRST,
  dm9000a_bus_ctrl_if.slave bus
);

  state_t            state_q, state_d;
  cnt_t              cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              cmd_q, cmd_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rst_n_q, rst_n_d;
  logic              cs_n_q, cs_n_d;
  logic              rd_n_q, rd_n_d;
  logic              wr_n_q, wr_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              last;

  // Next state, shared down-counter and next registered output values.
  // The counter is loaded with a phase length and the phase ends when it reads 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - cnt_t'(1);
    we_d    = we_q;
    cmd_d   = cmd_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    last    = (cnt_q == cnt_t'(1));

    case (state_q)
      ST_RST_LOW: begin
        if (last) begin
          state_d = ST_RST_WAIT;
          cnt_d   = cnt_t'(RST_WAIT);
        end
      end
      ST_RST_WAIT: begin
        if (last) begin
          state_d = ST_IDLE;
          cnt_d   = cnt_t'(0);
        end
      end
      ST_IDLE: begin
        cnt_d = cnt_q;
        if (bus.iREQ) begin
          state_d = ST_SETUP;
          cnt_d   = cnt_t'(SETUP_CYC);
          we_d    = bus.iWE;
          cmd_d   = bus.iCMD_SEL;
          data_d  = bus.iWDATA;
        end
      end
      ST_SETUP: begin
        if (last) begin
          state_d = ST_STROBE;
          cnt_d   = cnt_t'(PULSE_CYC);
        end
      end
      ST_STROBE: begin
        if (last) begin
          state_d = ST_HOLD;
          cnt_d   = cnt_t'(HOLD_CYC);
          if (!we_q) rdata_d = bus.iDATA;
        end
      end
      ST_HOLD: begin
        if (last) begin
          state_d = ST_IDLE;
          cnt_d   = cnt_t'(0);
        end
      end
      default: begin
        state_d = ST_RST_LOW;
        cnt_d   = cnt_t'(RST_CYC);
      end
    endcase

    rst_n_d = (state_d != ST_RST_LOW);
    cs_n_d  = (state_d inside {ST_RST_LOW, ST_RST_WAIT, ST_IDLE});
    rd_n_d  = !((state_d == ST_STROBE) && !we_d);
    wr_n_d  = !((state_d == ST_STROBE) && we_d);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_q == ST_HOLD) && (state_d == ST_IDLE);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= ST_RST_LOW;
      cnt_q   <= cnt_t'(RST_CYC);
      we_q    <= 1'b0;
      cmd_q   <= 1'b0;
      data_q  <= '0;
      rdata_q <= '0;
      rst_n_q <= 1'b0;
      cs_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      rst_n_q <= rst_n_d;
      cs_n_q  <= cs_n_d;
      rd_n_q  <= rd_n_d;
      wr_n_q  <= wr_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.oRDATA = rdata_q;
  assign bus.oBUSY  = busy_q;
  assign bus.oDONE  = done_q;
  assign bus.oDATA  = data_q;
  assign bus.oCMD   = cmd_q;
  assign bus.oRD_N  = rd_n_q;
  assign bus.oWR_N  = wr_n_q;
  assign bus.oCS_N  = cs_n_q;
  assign bus.oRST_N = rst_n_q;

  sync2 u_int_sync (
    .clk (iCLK),
    .rst (iRST),
    .d   (bus.iINT),
    .q   (bus.oINT)
  );

endmodule

// File: tb/tb_dm9000a_bus_ctrl.sv
// Randomised bench for dm9000a_bus_ctrl against a cycle-window timing model,
// plus a short directed run on a minimum-timing instance.
module tb_dm9000a_bus_ctrl;

  localparam int S  = 1;
  localparam int P  = 2;
  localparam int H  = 1;
  localparam int RC = 16;
  localparam int RW = 32;
  localparam int MAX_CYC = 4000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dm9000a_bus_ctrl_if bus ();
  dm9000a_bus_ctrl_if bus1 ();

  dm9000a_bus_ctrl #(
    .SETUP_CYC (S),
    .PULSE_CYC (P),
    .HOLD_CYC  (H),
    .RST_CYC   (RC),
    .RST_WAIT  (RW)
  ) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus.slave)
  );

  dm9000a_bus_ctrl #(
    .SETUP_CYC (1),
    .PULSE_CYC (1),
    .HOLD_CYC  (1),
    .RST_CYC   (4),
    .RST_WAIT  (4)
  ) dut1 (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus1.slave)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Model: an access accepted at acc_t occupies cycles acc_t+1 .. free_at-1,
  // strobe window acc_t+1+S .. acc_t+S+P, done at free_at. Reset starts at r0.
  int          r0, free_at, acc_t, last_rst;
  bit          acc_valid, acc_we;
  bit          exp_cmd;
  logic [15:0] exp_data, exp_rdata;
  logic [15:0] idata_hist [0:MAX_CYC+15];
  bit          int_hist   [0:MAX_CYC+15];
  bit          cur_int;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic do_cycle(input bit req, input bit we, input bit cmd,
                          input logic [15:0] wdata, input logic [15:0] idata,
                          input bit intr, input bit r);
    bit         in_acc, strobe, done_e;
    logic [5:0] exp_ctrl;
    @(posedge clk);
    #1;
    cyc++;
    rst          = r;
    bus.iREQ     = req;
    bus.iWE      = we;
    bus.iCMD_SEL = cmd;
    bus.iWDATA   = wdata;
    bus.iDATA    = idata;
    bus.iINT     = intr;
    idata_hist[cyc] = idata;
    int_hist[cyc]   = intr;
    @(negedge clk);

    in_acc = acc_valid && (cyc > acc_t) && (cyc < free_at);
    strobe = in_acc && (cyc >= acc_t + 1 + S) && (cyc <= acc_t + S + P);
    done_e = acc_valid && (cyc == free_at);
    if (done_e && !acc_we) exp_rdata = idata_hist[acc_t + S + P];

    exp_ctrl = {!(cyc >= r0 && cyc < r0 + RC), !in_acc, !(strobe && !acc_we),
                !(strobe && acc_we), (cyc < free_at), done_e};
    check("ctrl{rst_n,cs_n,rd_n,wr_n,busy,done}",
          32'({bus.oRST_N, bus.oCS_N, bus.oRD_N, bus.oWR_N, bus.oBUSY, bus.oDONE}),
          32'(exp_ctrl));
    check("strobe_excl", 32'(bus.oRD_N | bus.oWR_N), 32'd1);
    if (in_acc || cyc < free_at) begin
      check("cmd", 32'(bus.oCMD), 32'(exp_cmd));
      check("odata", 32'(bus.oDATA), 32'(exp_data));
    end
    if (!in_acc) check("rdata", 32'(bus.oRDATA), 32'(exp_rdata));
    check("oint", 32'(bus.oINT),
          32'((cyc >= last_rst + 3) ? int_hist[cyc-2] : 1'b0));

    if (r) begin
      r0        = cyc + 1;
      free_at   = r0 + RC + RW;
      acc_valid = 1'b0;
      exp_rdata = '0;
      exp_cmd   = 1'b0;
      exp_data  = '0;
      last_rst  = cyc;
    end else if (req && cyc >= free_at) begin
      acc_valid = 1'b1;
      acc_t     = cyc;
      acc_we    = we;
      exp_cmd   = cmd;
      exp_data  = wdata;
      free_at   = cyc + 1 + S + P + H;
    end
  endtask

  task automatic idle_cycle(input logic [15:0] idata);
    do_cycle(1'b0, 1'b0, 1'b0, 16'h0000, idata, cur_int, 1'b0);
  endtask

  task automatic wait_idle();
    while (cyc + 1 < free_at && cyc < MAX_CYC) idle_cycle(16'($urandom));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    {bus.iREQ, bus.iWE, bus.iCMD_SEL, bus.iINT}     = '0;
    {bus.iWDATA, bus.iDATA}                         = '0;
    {bus1.iREQ, bus1.iWE, bus1.iCMD_SEL, bus1.iINT} = '0;
    {bus1.iWDATA, bus1.iDATA}                       = '0;
    cur_int   = 1'b0;
    r0        = 1;
    free_at   = 1 + RC + RW;
    acc_valid = 1'b0;
    acc_we    = 1'b0;
    acc_t     = 0;
    last_rst  = 0;
    exp_cmd   = 1'b0;
    exp_data  = '0;
    exp_rdata = '0;
    repeat (3) @(posedge clk);

    // Reset release, then a directed index-port write.
    wait_idle();
    do_cycle(1'b1, 1'b1, 1'b0, 16'h00FE, 16'h5555, cur_int, 1'b0);
    repeat (6) idle_cycle(16'h1111);

    // Directed data-port read with iDATA held at 0x0A46.
    wait_idle();
    do_cycle(1'b1, 1'b0, 1'b1, 16'hBEEF, 16'h0A46, cur_int, 1'b0);
    repeat (6) idle_cycle(16'h0A46);

    // Interrupt edge.
    cur_int = 1'b1;
    repeat (4) idle_cycle(16'h2222);

    // iREQ held high: back-to-back accesses.
    for (int i = 0; i < 40; i++)
      do_cycle(1'b1, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), cur_int, 1'b0);

    // Reset during the strobe of a write.
    wait_idle();
    do_cycle(1'b1, 1'b1, 1'b1, 16'hA5A5, 16'h0, cur_int, 1'b0);
    idle_cycle(16'h0);
    do_cycle(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, cur_int, 1'b1);
    repeat (RC + RW + 6) idle_cycle(16'($urandom));

    // Random traffic with occasional resets and interrupt toggles.
    for (int i = 0; i < 1500 && cyc < MAX_CYC - 10; i++) begin
      if ($urandom_range(0, 7) == 0) cur_int = ~cur_int;
      do_cycle($urandom_range(0, 2) == 0, 1'($urandom), 1'($urandom),
               16'($urandom), 16'($urandom), cur_int,
               $urandom_range(0, 299) == 0);
    end

    // Minimum-timing instance: access latency and interrupt latency.
    rst = 1'b0;
    for (int i = 0; i < 100 && bus1.oBUSY !== 1'b0; i++) @(negedge clk);
    check("dut1_idle", 32'(bus1.oBUSY), 32'd0);
    @(posedge clk);
    #1;
    bus1.iREQ     = 1'b1;
    bus1.iWE      = 1'b1;
    bus1.iCMD_SEL = 1'b1;
    bus1.iWDATA   = 16'h1234;
    bus1.iINT     = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("dut1_cs_n", 32'(bus1.oCS_N), 32'(!(k >= 1 && k <= 3)));
      check("dut1_wr_n", 32'(bus1.oWR_N), 32'(k != 2));
      check("dut1_done", 32'(bus1.oDONE), 32'(k == 4));
      check("dut1_oint", 32'(bus1.oINT), 32'(k >= 2));
      if (k >= 1 && k <= 3) check("dut1_odata", 32'(bus1.oDATA), 32'h1234);
      @(posedge clk);
      #1;
      bus1.iREQ = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dm9000a_bus_ctrl.md
DM9000A_BUS_CTRL -- requirements
Module: dm9000a_bus_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning), each legal range 1..255:
  SETUP_CYC  1   cycles CS_N/CMD/data are valid before the strobe
  PULSE_CYC  2   cycles RD_N or WR_N is held low
  HOLD_CYC   1   cycles CS_N/CMD/data are held after the strobe
  RST_CYC    16  cycles oRST_N is held low after reset
  RST_WAIT   32  cycles after oRST_N rises before the first access
REQ-002 Ports SHALL be (name, direction, width, meaning):
  iCLK     in   1   sole clock, rising edge
  iRST     in   1   synchronous, active-high reset
  iREQ     in   1   host access request
  iWE      in   1   1 = write, 0 = read
  iCMD_SEL in   1   DM9000A CMD value: 0 = index port, 1 = data port
  iWDATA   in   16  write data
  oRDATA   out  16  read data, valid from the oDONE cycle until the next read completes
  oBUSY    out  1   1 = iREQ is ignored
  oDONE    out  1   one-cycle pulse marking access completion
  oDATA    out  16  write data toward the DM9000A pad interface
  iDATA    in   16  read data from the DM9000A pad interface
  oCMD, oRD_N, oWR_N, oCS_N, oRST_N  out  1 each  DM9000A bus controls
  iINT     in   1   raw DM9000A interrupt
  oINT     out  1   synchronised interrupt
REQ-003 The block SHALL have exactly one clock, iCLK; iRST SHALL be synchronous and active-high.

Function
REQ-004 FSM states SHALL be RST_LOW, RST_WAIT, IDLE, SETUP, STROBE and HOLD, sharing one 8-bit down-counter.
REQ-005 In RST_LOW, oRST_N=0 for exactly RST_CYC cycles, then the FSM SHALL enter RST_WAIT.
REQ-006 In RST_WAIT, oRST_N=1 for exactly RST_WAIT cycles, then the FSM SHALL enter IDLE.
REQ-007 In IDLE, iREQ=1 SHALL latch iWE, iCMD_SEL and iWDATA, and enter SETUP on the next cycle.
REQ-008 In SETUP (SETUP_CYC cycles), oCS_N=0, oCMD=latched value, oRD_N=oWR_N=1.
REQ-009 In STROBE (PULSE_CYC cycles), oCS_N=0 and oWR_N=0 for a write, or oRD_N=0 for a read.
REQ-010 In HOLD (HOLD_CYC cycles), oCS_N=0, both strobes=1 and oCMD/oDATA SHALL remain unchanged.
REQ-011 After HOLD, the FSM SHALL return to IDLE and assert oDONE for that first IDLE cycle only.
REQ-012 Reads SHALL capture iDATA into oRDATA on the last STROBE cycle.
REQ-013 oDATA SHALL equal the latched write data from SETUP through HOLD.
REQ-014 Access latency SHALL be: iREQ accepted at cycle t -> oDONE at t+1+SETUP_CYC+PULSE_CYC+HOLD_CYC (t+5 with defaults).
REQ-015 oBUSY SHALL be 0 only in IDLE; iREQ outside IDLE SHALL be ignored and not queued.
REQ-016 Back-to-back: iREQ=1 in the oDONE cycle SHALL be accepted, because that cycle is IDLE.
REQ-017 oRD_N and oWR_N SHALL never be low simultaneously; oCS_N=1 in RST_LOW, RST_WAIT and IDLE.
REQ-018 oINT SHALL be iINT through a two-flop synchroniser, giving a 2-cycle latency.
REQ-019 All outputs SHALL be registered.

Reset
REQ-020 iRST=1 in any state, including mid-access, SHALL force RST_LOW on the next edge and abort the access without asserting oDONE.
REQ-021 Reset values SHALL be: oRST_N=0, oCS_N=1, oRD_N=1, oWR_N=1, oCMD=0, oDATA=0, oRDATA=0, oBUSY=1, oDONE=0, oINT=0, synchroniser flops=0.
REQ-022 Holding iRST high SHALL keep the FSM in RST_LOW with the counter reloaded to RST_CYC.

Structure
REQ-023 Package dm9000a_pkg SHALL hold the state enum, the default timing constants and the 8-bit counter width.
REQ-024 The interrupt synchroniser SHALL be sub-module sync2 (1-bit, two flops, synchronous active-high reset).
REQ-025 The outputs SHALL connect one-to-one to the DM9000A pad interface's host ports (iDATA/oDATA, iCMD, iRD_N, iWR_N, iCS_N, iRST_N, oINT).

Verification
REQ-026 Reset release with defaults -> oRST_N low for 16 cycles, high, oBUSY=1 for 32 more cycles, then oBUSY=0.
REQ-027 Write with iCMD_SEL=0, iWDATA=16'h00FE, accepted at t -> oCS_N low t+1..t+4, oWR_N low t+2..t+3, oDATA=16'h00FE, oCMD=0, oDONE=1 at t+5 only.
REQ-028 Read with iCMD_SEL=1, model drives iDATA=16'h0A46 during STROBE -> oRD_N low 2 cycles, oRDATA=16'h0A46 at oDONE.
REQ-029 iREQ held high continuously -> accesses issued every 5 cycles, and iREQ pulses while oBUSY=1 produce no extra access.
REQ-030 iRST asserted during STROBE of a write -> oWR_N=1 and oCS_N=1 next cycle, no oDONE, full reset sequence repeats.
REQ-031 iINT 0->1 -> oINT=1 exactly 2 cycles later; with SETUP_CYC=PULSE_CYC=HOLD_CYC=1, oDONE at t+4.
